edge_timestamp_fifo: RTL and testbench
======================================

// Module: edge_timestamp_fifo
// PURPOSE
//  Downstream consumer of the edge detector's single-cycle dout pulse. Stamps each pulse with a
//  free-running cycle counter and buffers the stamps in a first-word-fall-through FIFO.
//  The FIFO drains through a valid/ready read port to the register/readout logic.
//  Overflow is flagged, not silently lost.
// PARAMETERS
//  TS_W    32  timestamp counter width (bits); also the read data width
//  ADDR_W  4   FIFO address width; depth = 2**ADDR_W entries (default 16)
// PORTS
//  clk       in   1         system clock; all logic on rising edge
//  enable    in   1         async active-low reset: low clears everything, high runs
//  pulse_in  in   1         single-cycle edge pulse from edge detector dout
//  ts_clr    in   1         sync clear of timestamp counter (counter=0 next cycle)
//  rd_ready  in   1         consumer ready; pop occurs when rd_valid & rd_ready
//  rd_valid  out  1         FIFO non-empty; rd_data valid
//  rd_data   out  TS_W      oldest stored timestamp (head of FIFO)
//  level     out  ADDR_W+1  number of stored entries, 0..2**ADDR_W
//  ovf       out  1         sticky: a pulse arrived while FIFO full and was dropped
//  ovf_clr   in   1         sync clear of ovf
//  ts_wrap   out  1         one-cycle pulse when counter rolls over all-ones -> 0
//  drop_cnt  out  16        dropped-pulse count (TAG_DROP_CNT_EN builds only)
// BEHAVIOUR
//  - Reset (enable low, async): counter=0, FIFO empty (wr/rd ptr=0, level=0), rd_valid=0,
//    rd_data=0, ovf=0, ts_wrap=0, drop_cnt=0. Pulses ignored while low. Reset mid-stream discards
//    all stored entries; first stamp after release is relative to counter=0.
//  - Counter: +1 every cycle mod 2**TS_W. ts_clr loads 0 (priority over increment; no ts_wrap).
//    ts_wrap=1 for the single cycle after counter goes all-ones -> 0 by increment.
//  - Capture: pulse_in=1 in cycle t writes the counter's registered value in cycle t.
//    If ts_clr is also high in cycle t, the pre-clear value is written.
//  - Latency: write in cycle t -> rd_valid=1 and rd_data=stamp in cycle t+1 (FWFT, when empty).
//  - Read: pop when rd_valid & rd_ready; next entry is presented the following cycle.
//    rd_data is held stable while rd_valid & ~rd_ready.
//  - Full (level=2**ADDR_W):
//    - pulse_in with no pop: entry dropped, ovf<=1, drop_cnt+1 (if built).
//    - pulse_in with a pop in the same cycle: write accepted, level unchanged.
//  - Empty: rd_valid=0. Pulse in the same cycle: write only. Pop not possible.
//  - Simultaneous push and pop when not full/empty: level unchanged, order preserved.
//  - Pointers wrap mod 2**ADDR_W. Full/empty come from level, not pointer equality alone.
//  - ovf_clr clears ovf. If ovf_clr and a drop coincide, ovf stays 1 (set wins).
//  - ovf does not block writes once space exists.
//  - Back-to-back pulses every cycle are all captured until full.
//  - Write-port arithmetic: unsigned, width TS_W, no saturation.
// CONFIGURATION
//  TAG_DROP_CNT_EN defined: 16-bit drop_cnt counts every dropped pulse.
//    Saturates at 16'hFFFF. Cleared by ovf_clr, or by reset.
//    Same-cycle ovf_clr and drop -> drop_cnt=1.
//  TAG_DROP_CNT_EN undefined: drop_cnt port present, tied to 16'h0; no counter logic.
// TESTING
//  1. Release enable at cycle 0, pulse_in at cycle 5, rd_ready=1 -> rd_valid at cycle 6,
//     rd_data=5, level 1 -> 0 after the pop.
//  2. rd_ready=0, 16 pulses at cycles 10..25 -> level=16, ovf=0.
//     17th pulse at 30 -> ovf=1, level=16, drop_cnt=1 (macro on).
//     Drain -> data 10..25 in order.
//  3. Full FIFO, pulse_in and pop in the same cycle -> level stays 16,
//     new stamp appears as last entry, ovf unchanged.
//  4. TS_W=8: run 256 cycles -> ts_wrap pulses once as counter 255 -> 0.
//     Pulse at that cycle stamps 0. ts_clr with pulse_in at counter=77 -> stamp 77, counter 0 next.
//  5. 5 entries stored, enable low for 1 cycle mid-read -> level=0, rd_valid=0, ovf=0
//     immediately (async). Next pulse stamps a small post-reset count.
//  6. ovf=1, ovf_clr and an overflow drop in the same cycle -> ovf stays 1,
//     drop_cnt=1 (macro on) / 0 (macro off).

Source files
------------

// File: rtl/edge_timestamp_fifo.sv
// edge_timestamp_fifo: stamps edge pulses with a free-running counter into a FWFT FIFO.
// Define TAG_DROP_CNT_EN to build the saturating 16-bit dropped-pulse counter.
module edge_timestamp_fifo #(
  parameter int TS_W   = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              enable,
  input  logic              pulse_in,
  input  logic              ts_clr,
  input  logic              rd_ready,
  input  logic              ovf_clr,
  output logic              rd_valid,
  output logic [TS_W-1:0]   rd_data,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              ts_wrap,
  output logic [15:0]       drop_cnt
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  logic [TS_W-1:0]   cnt;
  logic [TS_W-1:0]   mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic full, pop, push, drop;
  assign full     = level == DEPTH;
  assign rd_valid = level != '0;
  assign pop      = rd_valid & rd_ready;
  assign push     = pulse_in & (~full | pop);
  assign drop     = pulse_in & full & ~pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      cnt     <= '0;
      ts_wrap <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf     <= 1'b0;
    end else begin
      cnt     <= ts_clr ? '0 : cnt + 1'b1;
      ts_wrap <= ~ts_clr & (&cnt);
      wr_ptr  <= wr_ptr + ADDR_W'(push);
      rd_ptr  <= rd_ptr + ADDR_W'(pop);
      level   <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      ovf     <= drop | (ovf & ~ovf_clr);
    end
  end
  // Storage needs no reset: level gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push & enable) mem[wr_ptr] <= cnt;
  end
`ifdef TAG_DROP_CNT_EN
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) drop_cnt <= '0;
    else if (ovf_clr) drop_cnt <= 16'(drop);
    else if (drop & ~&drop_cnt) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_edge_timestamp_fifo.sv
// tb_edge_timestamp_fifo: scoreboard bench for edge_timestamp_fifo built with TS_W=8, ADDR_W=4.
module tb_edge_timestamp_fifo;
  logic clk = 1'b0, enable = 1'b0, pulse_in = 1'b0, ts_clr = 1'b0, rd_ready = 1'b0, ovf_clr = 1'b0;
  logic rd_valid, ovf, ts_wrap;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic [15:0] drop_cnt;
  logic [7:0] m_cnt;
  logic [7:0] q[$];
  int checks = 0, errors = 0;
`ifdef TAG_DROP_CNT_EN
  localparam logic [15:0] DC1 = 16'd1;
`else
  localparam logic [15:0] DC1 = 16'd0;
`endif

  edge_timestamp_fifo #(.TS_W(8), .ADDR_W(4)) dut (
    .clk(clk), .enable(enable), .pulse_in(pulse_in), .ts_clr(ts_clr), .rd_ready(rd_ready),
    .ovf_clr(ovf_clr), .rd_valid(rd_valid), .rd_data(rd_data), .level(level), .ovf(ovf),
    .ts_wrap(ts_wrap), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle counter, the value a pulse in the current cycle must capture.
  always @(posedge clk or negedge enable)
    if (!enable) m_cnt <= '0;
    else m_cnt <= ts_clr ? 8'd0 : m_cnt + 8'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill16();
    rd_ready = 1'b0;
    repeat (16) begin
      pulse_in = 1'b1;
      q.push_back(m_cnt);
      tick();
    end
    pulse_in = 1'b0;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    while (m_cnt != v && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (m_cnt != v) begin
      errors++;
      $display("FAIL wait_cnt: counter got %0d want %0d", m_cnt, v);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    tick();
    checks++;
    if ({rd_valid, rd_data, level, ovf, ts_wrap, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b d=%0d lvl=%0d ovf=%b wrap=%b dc=%0d want all 0",
               rd_valid, rd_data, level, ovf, ts_wrap, drop_cnt);
    end
    enable = 1'b1;
  endtask

  task automatic test_single();
    repeat (5) tick();
    pulse_in = 1'b1;
    rd_ready = 1'b1;
    q.push_back(m_cnt);
    tick();
    pulse_in = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || level !== 5'd1 || rd_data !== 8'd5) begin
      errors++;
      $display("FAIL single: got v=%b lvl=%0d d=%0d want v=1 lvl=1 d=5", rd_valid, level, rd_data);
    end
    checks++;
    if (rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL single_sb: got d=%0d", rd_data);
    end
    tick();
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: got v=%b lvl=%0d want v=0 lvl=0", rd_valid, level);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] head;
    fill16();
    checks++;
    if (level !== 5'd16 || ovf !== 1'b0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL full: got lvl=%0d ovf=%b v=%b want lvl=16 ovf=0 v=1", level, ovf, rd_valid);
    end
    head = rd_data;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    checks++;
    if (level !== 5'd16 || ovf !== 1'b1 || drop_cnt !== DC1) begin
      errors++;
      $display("FAIL overflow: got lvl=%0d ovf=%b dc=%0d want lvl=16 ovf=1 dc=%0d", level, ovf, drop_cnt, DC1);
    end
    checks++;
    if (rd_data !== head || rd_data !== q[0]) begin
      errors++;
      $display("FAIL hold: got d=%0d want %0d", rd_data, q[0]);
    end
  endtask

  task automatic test_full_push_pop();
    int bad = 0;
    rd_ready = 1'b1;
    pulse_in = 1'b1;
    checks++;
    if (rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL fpp_head: got d=%0d", rd_data);
    end
    q.push_back(m_cnt);
    tick();
    rd_ready = 1'b0;
    pulse_in = 1'b0;
    checks++;
    if (level !== 5'd16 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%b want lvl=16 ovf=1", level, ovf);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = q.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        bad++;
        $display("FAIL drain[%0d]: got v=%b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, e);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: got lvl=%0d v=%b want 0 0", level, rd_valid);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr: got ovf=%b dc=%0d want 0 0", ovf, drop_cnt);
    end
  endtask

  task automatic test_ovf_clr_drop();
    fill16();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b1;
    ovf_clr = 1'b1;
    tick();
    pulse_in = 1'b0;
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || drop_cnt !== DC1 || level !== 5'd16) begin
      errors++;
      $display("FAIL clr_vs_drop: got ovf=%b dc=%0d lvl=%0d want ovf=1 dc=%0d lvl=16", ovf, drop_cnt, level, DC1);
    end
  endtask

  task automatic test_mid_reset();
    rd_ready = 1'b1;
    checks++;
    if (rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL mid_read: got d=%0d", rd_data);
    end
    @(posedge clk);
    #2;
    rd_ready = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d v=%b ovf=%b dc=%0d want all 0", level, rd_valid, ovf, drop_cnt);
    end
    q.delete();
    enable = 1'b1;
    tick();
    tick();
    pulse_in = 1'b1;
    q.push_back(m_cnt);
    tick();
    pulse_in = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd2 || rd_data !== q[0]) begin
      errors++;
      $display("FAIL post_reset_stamp: got v=%b d=%0d want v=1 d=2", rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    void'(q.pop_front());
    tick();
  endtask

  task automatic test_wrap();
    int wraps = 0;
    rd_ready = 1'b1;
    wait_cnt(8'd255);
    checks++;
    if (ts_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_early: got %b want 0", ts_wrap);
    end
    tick();
    pulse_in = 1'b1;
    q.push_back(m_cnt);
    checks++;
    if (ts_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pulse: got %b want 1", ts_wrap);
    end
    tick();
    pulse_in = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd0 || rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL wrap_stamp: got v=%b d=%0d want v=1 d=0", rd_valid, rd_data);
    end
    repeat (256) begin
      tick();
      if (ts_wrap === 1'b1) wraps++;
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 1", wraps);
    end
    wait_cnt(8'd77);
    pulse_in = 1'b1;
    ts_clr = 1'b1;
    q.push_back(m_cnt);
    tick();
    ts_clr = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd77 || rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL clr_stamp: got v=%b d=%0d want v=1 d=77", rd_valid, rd_data);
    end
    q.push_back(m_cnt);
    tick();
    pulse_in = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'd0 || rd_data !== q.pop_front()) begin
      errors++;
      $display("FAIL after_clr: got v=%b d=%0d want v=1 d=0", rd_valid, rd_data);
    end
    wait_cnt(8'd255);
    ts_clr = 1'b1;
    tick();
    ts_clr = 1'b0;
    checks++;
    if (ts_wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_wrap: got %b want 0", ts_wrap);
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_ovf_clr_drop();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
